bitserial_mul_seq: RTL
======================

// Module: bitserial_mul_seq
// PURPOSE
//  Operand sequencer that sits directly upstream of the bit-serial multiplier (topmul).
//  Accepts operand pairs over a valid/ready handshake and drives topmul's a/b/rst.
//  Waits the multiplier's fixed latency, then captures q and presents it with a valid/ready handshake.
//  Replaces the hand-sequenced rst/a/b stimulus so the multiplier can be used back-to-back.
// PARAMETERS
//  W          8    operand width; result is 2*W
//  CLR_CYCLES 1    cycles mul_rst is held high before each multiply (>=1)
//  LATENCY    W+2  cycles after mul_rst falls until mul_q is final (>=1)
// PORTS
//  clk        in   1    clock, rising edge
//  rst        in   1    asynchronous, active-low reset
//  in_valid   in   1    operand pair valid
//  in_ready   out  1    sequencer can accept operands
//  in_a       in   W    multiplicand
//  in_b       in   W    multiplier
//  mul_a      out  W    to topmul.a, held stable for the whole multiply
//  mul_b      out  W    to topmul.b, held stable for the whole multiply
//  mul_rst    out  1    to topmul.rst (active-high clear)
//  mul_q      in   2W   from topmul.q
//  out_valid  out  1    out_q holds a finished product
//  out_ready  in   1    consumer takes out_q
//  out_q      out  2W   captured product
//  busy       out  1    state != IDLE
// BEHAVIOUR
//  Reset (rst=0): state=IDLE, cnt=0, mul_a=mul_b=0, mul_rst=1, out_valid=0, out_q=0.
//   in_ready=0 while rst=0.
//  FSM IDLE/CLEAR/RUN/DONE, all registered; in_ready is combinational:
//   in_ready = (IDLE) | (DONE & out_ready).
//  IDLE: mul_rst=1. On in_valid&in_ready, latch in_a/in_b into mul_a/mul_b, cnt=0 -> CLEAR.
//  CLEAR: mul_rst=1; cnt counts to CLR_CYCLES-1, then cnt=0, mul_rst<=0 -> RUN.
//  RUN: mul_rst=0; cnt increments each cycle.
//   At the edge where cnt==LATENCY-1: out_q<=mul_q, out_valid<=1, mul_rst<=1 -> DONE.
//  DONE: out_valid=1, out_q stable until handshake (out_valid&out_ready).
//   Handshake with no in_valid: out_valid<=0 -> IDLE.
//   Handshake with in_valid (simultaneous): latch new operands -> CLEAR, out_valid<=0; no bubble cycle.
//  Latency: operands accepted at edge E0 -> out_valid high after edge E0+CLR_CYCLES+LATENCY.
//  Throughput: one product per CLR_CYCLES+LATENCY+1 cycles with out_ready held high.
//  in_valid outside in_ready is ignored. Inputs are not stored; the upstream block holds them until accepted.
//  mul_a/mul_b change only on an accepting edge. They never change while mul_rst=0.
//  out_ready without out_valid has no effect. out_q keeps its last product after the handshake.
//  cnt is wide enough for max(CLR_CYCLES,LATENCY)-1 and never wraps past its terminal value.
//  Product width: out_q is 2W unsigned, copied from mul_q unmodified. No truncation or sign handling.
//  Async reset mid-operation: immediate return to reset values. The in-flight product is discarded.
//   First accept after release starts a full CLEAR+RUN.
//  out_valid never asserts without a complete CLEAR+RUN since the last accept.
// TESTING
//  1. Reset for 3 cycles, then in_a=129, in_b=56, in_valid=1 for one cycle ->
//     out_valid rises exactly CLR_CYCLES+LATENCY cycles later, out_q=7224.
//  2. Back-to-back: out_ready=1, second pair 255x255 offered while DONE ->
//     out_q=7224 then 65025; no idle cycle between the handshake and CLEAR.
//  3. Backpressure: out_ready=0 for 20 cycles after 12x13 completes ->
//     out_valid and out_q=156 stay stable, in_ready=0; released on out_ready=1.
//  4. Boundaries: 0x200=0, 1x1=1, 255x1=255, 255x255=65025.
//     mul_a/mul_b stay constant through RUN in every case.
//  5. Assert rst=0 mid-RUN of 100x100 -> all outputs return to reset values immediately.
//     Next 3x7 yields out_q=21 with correct latency; 10000 is never presented.
//  6. in_valid toggled while busy (not DONE&out_ready) -> ignored;
//     out_q reflects only the accepted pair, checked against a*b scoreboard.

Source files
------------

// File: rtl/bitserial_mul_seq.sv
// Operand sequencer for the bit-serial multiplier: accepts operand pairs, clears and runs
// the multiplier for a fixed latency, then holds the captured product under valid/ready.
module bitserial_mul_seq #(
  parameter int unsigned W          = 8,
  parameter int unsigned CLR_CYCLES = 1,
  parameter int unsigned LATENCY    = W + 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_a,
  input  logic [W-1:0]   in_b,
  output logic [W-1:0]   mul_a,
  output logic [W-1:0]   mul_b,
  output logic           mul_rst,
  input  logic [2*W-1:0] mul_q,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] out_q,
  output logic           busy
);

  localparam int unsigned MAXC = (CLR_CYCLES > LATENCY) ? CLR_CYCLES : LATENCY;
  localparam int unsigned CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] CLR_LAST = CW'(CLR_CYCLES - 1);
  localparam logic [CW-1:0] LAT_LAST = CW'(LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_RUN, S_DONE} state_t;

  state_t         r_state, w_state_nx;
  logic [CW-1:0]  r_cnt, w_cnt_nx;
  logic [W-1:0]   r_mul_a, w_mul_a_nx;
  logic [W-1:0]   r_mul_b, w_mul_b_nx;
  logic           r_mul_rst, w_mul_rst_nx;
  logic           r_out_valid, w_out_valid_nx;
  logic [2*W-1:0] r_out_q, w_out_q_nx;
  logic           w_in_ready;
  logic           w_accept;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_mul_a     <= '0;
      r_mul_b     <= '0;
      r_mul_rst   <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_q     <= '0;
    end else begin
      r_state     <= w_state_nx;
      r_cnt       <= w_cnt_nx;
      r_mul_a     <= w_mul_a_nx;
      r_mul_b     <= w_mul_b_nx;
      r_mul_rst   <= w_mul_rst_nx;
      r_out_valid <= w_out_valid_nx;
      r_out_q     <= w_out_q_nx;
    end
  end

  always_comb begin
    w_state_nx     = r_state;
    w_cnt_nx       = r_cnt;
    w_mul_a_nx     = r_mul_a;
    w_mul_b_nx     = r_mul_b;
    w_mul_rst_nx   = r_mul_rst;
    w_out_valid_nx = r_out_valid;
    w_out_q_nx     = r_out_q;
    // Gated by rst so nothing is accepted while the block is held in reset.
    w_in_ready = rst & ((r_state == S_IDLE) | ((r_state == S_DONE) & out_ready));
    w_accept   = in_valid & w_in_ready;

    unique case (r_state)
      S_IDLE: begin
        w_mul_rst_nx = 1'b1;
      end
      S_CLEAR: begin
        if (r_cnt == CLR_LAST) begin
          w_cnt_nx     = '0;
          w_mul_rst_nx = 1'b0;
          w_state_nx   = S_RUN;
        end else begin
          w_cnt_nx = r_cnt + CW'(1);
        end
      end
      S_RUN: begin
        if (r_cnt == LAT_LAST) begin
          w_out_q_nx     = mul_q;
          w_out_valid_nx = 1'b1;
          w_mul_rst_nx   = 1'b1;
          w_state_nx     = S_DONE;
        end else begin
          w_cnt_nx = r_cnt + CW'(1);
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_out_valid_nx = 1'b0;
          w_state_nx     = S_IDLE;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase

    // A simultaneous handshake and accept in DONE goes straight to CLEAR.
    if (w_accept) begin
      w_mul_a_nx   = in_a;
      w_mul_b_nx   = in_b;
      w_cnt_nx     = '0;
      w_mul_rst_nx = 1'b1;
      w_state_nx   = S_CLEAR;
    end
  end

  assign in_ready  = w_in_ready;
  assign mul_a     = r_mul_a;
  assign mul_b     = r_mul_b;
  assign mul_rst   = r_mul_rst;
  assign out_valid = r_out_valid;
  assign out_q     = r_out_q;
  assign busy      = (r_state != S_IDLE);

endmodule
